// File: rtl/starforc_audio_out.sv
// Star Force audio output stage: box-car decimation, optional DC block, master gain, saturation, valid/ready output.
// Optional DC block is compiled in when STARFORC_AUDIO_DCBLOCK_EN is defined.
module starforc_audio_out #(
  parameter int LOG2_DECIM = 4,
  parameter int DC_SHIFT   = 10
) (
  input  logic        clk12m,
  input  logic        nRESET,
  input  logic        smp_ce,
  input  logic [15:0] sout,
  input  logic [3:0]  gain,
  input  logic        mute,
  output logic [15:0] aud_out,
  output logic        aud_valid,
  input  logic        aud_ready,
  output logic [7:0]  drop_cnt
);

  // Handshake: aud_out carries a sample whenever aud_valid is high; the sample is
  // consumed at a posedge with aud_valid & aud_ready. A new sample arriving while the
  // old one is still unconsumed overwrites it and bumps drop_cnt.

  localparam int AW    = 16 + LOG2_DECIM;
  localparam int DECIM = 1 << LOG2_DECIM;

  logic [AW-1:0]         acc_q;
  logic [LOG2_DECIM-1:0] phase_q;
  logic [15:0]           avg_q;
  logic                  v1_q, v2_q, v3_q;
  logic signed [23:0]    y_q;
  logic [15:0]           p_q;
  logic [15:0]           aud_out_q;
  logic                  aud_valid_q;
  logic [7:0]            drop_cnt_q;

  logic [AW-1:0]         acc_sum_d;
  logic                  frame_end_d;
  logic signed [15:0]    x_d;
  logic signed [23:0]    x_ext_d;
  logic signed [23:0]    y_d;
  logic signed [28:0]    prod_d;
  logic signed [28:0]    p_full_d;
  logic [15:0]           p_d;

  always_comb begin
    acc_sum_d   = acc_q + AW'(sout);
    frame_end_d = smp_ce && (phase_q == LOG2_DECIM'(DECIM - 1));
  end

  // S0: accumulate DECIM samples, then emit their mean
  always_ff @(posedge clk12m or negedge nRESET) begin
    if (!nRESET) begin
      acc_q   <= '0;
      phase_q <= '0;
      avg_q   <= '0;
      v1_q    <= 1'b0;
    end else begin
      v1_q <= frame_end_d;
      if (frame_end_d) begin
        avg_q   <= acc_sum_d[AW-1:LOG2_DECIM];
        acc_q   <= '0;
        phase_q <= '0;
      end else if (smp_ce) begin
        acc_q   <= acc_sum_d;
        phase_q <= phase_q + 1'b1;
      end
    end
  end

  always_comb begin
    x_d     = {~avg_q[15], avg_q[14:0]};
    x_ext_d = {{8{x_d[15]}}, x_d};
  end

`ifdef STARFORC_AUDIO_DCBLOCK_EN
  logic signed [23:0] x1_q, y1_q;

  always_comb begin
    y_d = x_ext_d - x1_q + y1_q - (y1_q >>> DC_SHIFT);
  end

  always_ff @(posedge clk12m or negedge nRESET) begin
    if (!nRESET) begin
      x1_q <= '0;
      y1_q <= '0;
    end else if (v1_q) begin
      x1_q <= x_ext_d;
      y1_q <= y_d;
    end
  end
`else
  always_comb begin
    y_d = x_ext_d;
  end
`endif

  // S1: centred (and optionally DC-blocked) sample
  always_ff @(posedge clk12m or negedge nRESET) begin
    if (!nRESET) begin
      y_q  <= '0;
      v2_q <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) y_q <= y_d;
    end
  end

  // Gain is unsigned 0..15 with unity at 8; product fits easily in 29 bits.
  always_comb begin
    prod_d   = {{5{y_q[23]}}, y_q} * {25'd0, gain};
    p_full_d = prod_d >>> 3;
    if (mute)
      p_d = 16'h0000;
    else if (p_full_d > 29'sd32767)
      p_d = 16'h7FFF;
    else if (p_full_d < -29'sd32768)
      p_d = 16'h8000;
    else
      p_d = p_full_d[15:0];
  end

  // S2: gain + saturate
  always_ff @(posedge clk12m or negedge nRESET) begin
    if (!nRESET) begin
      p_q  <= '0;
      v3_q <= 1'b0;
    end else begin
      v3_q <= v2_q;
      if (v2_q) p_q <= p_d;
    end
  end

  // Output register: a new sample always wins; unconsumed old samples are counted as lost
  always_ff @(posedge clk12m or negedge nRESET) begin
    if (!nRESET) begin
      aud_out_q   <= '0;
      aud_valid_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else if (v3_q) begin
      aud_out_q   <= p_q;
      aud_valid_q <= 1'b1;
      if (aud_valid_q && !aud_ready && (drop_cnt_q != 8'hFF))
        drop_cnt_q <= drop_cnt_q + 8'd1;
    end else if (aud_valid_q && aud_ready) begin
      aud_valid_q <= 1'b0;
    end
  end

  assign aud_out   = aud_out_q;
  assign aud_valid = aud_valid_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_starforc_audio_out.sv
// Self-checking bench for starforc_audio_out: vector table, randomized frames against a
// reference model, and hand sequences for reset, back-pressure and simultaneous handshake.
module tb_starforc_audio_out;

  localparam int DECIM    = 16;
  localparam int DC_SHIFT = 10;

  logic        clk12m;
  logic        nRESET;
  logic        smp_ce;
  logic [15:0] sout;
  logic [3:0]  gain;
  logic        mute;
  logic [15:0] aud_out;
  logic        aud_valid;
  logic        aud_ready;
  logic [7:0]  drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  int mx1 = 0;
  int my1 = 0;

  typedef struct {
    logic [15:0] sout;
    logic [3:0]  gain;
    logic        mute;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[8];

  starforc_audio_out dut (
    .clk12m   (clk12m),
    .nRESET   (nRESET),
    .smp_ce   (smp_ce),
    .sout     (sout),
    .gain     (gain),
    .mute     (mute),
    .aud_out  (aud_out),
    .aud_valid(aud_valid),
    .aud_ready(aud_ready),
    .drop_cnt (drop_cnt)
  );

  // clock / reset
  initial clk12m = 1'b0;
  always #5 clk12m = ~clk12m;

  task automatic tick();
    @(posedge clk12m);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model: mean of DECIM inputs, centre, optional leaky DC block, gain, clamp
  function automatic logic [15:0] model_sample(input int avg, input int g, input bit m);
    int x, y, p;
    logic [15:0] r;
    x = avg - 32768;
`ifdef STARFORC_AUDIO_DCBLOCK_EN
    y = x - mx1 + my1 - (my1 >>> DC_SHIFT);
    y = (y <<< 8) >>> 8;
    mx1 = x;
    my1 = y;
`else
    y = x;
`endif
    p = (y * g) >>> 3;
    if (m) r = 16'h0000;
    else if (p > 32767) r = 16'h7FFF;
    else if (p < -32768) r = 16'h8000;
    else r = p[15:0];
    return r;
  endfunction

  task automatic do_reset();
    smp_ce = 1'b0;
    nRESET = 1'b0;
    repeat (3) tick();
    nRESET = 1'b1;
    tick();
    mx1 = 0;
    my1 = 0;
    exp_q.delete();
  endtask

  // driver: DECIM strobes (constant or random data), random gaps; returns at #1 after the last sampling edge
  task automatic send_frame(input bit rnd, input logic [15:0] cval, input int gap_max);
    longint sum;
    logic [15:0] v;
    sum = 0;
    for (int i = 0; i < DECIM; i++) begin
      v = rnd ? 16'($urandom_range(0, 65535)) : cval;
      sum += v;
      smp_ce = 1'b1;
      sout   = v;
      tick();
      smp_ce = 1'b0;
      sout   = 16'($urandom_range(0, 65535));
      if (i != DECIM - 1) repeat ($urandom_range(0, gap_max)) tick();
    end
    exp_q.push_back(model_sample(int'(sum / DECIM), int'(gain), mute));
  endtask

  task automatic wait_valid(input string name, input int bound);
    int k;
    k = 0;
    while (!aud_valid && k < bound) begin
      tick();
      k++;
    end
    n_cmp++;
    if (!aud_valid) begin
      n_err++;
      $display("FAIL %s: aud_valid not seen within %0d cycles", name, bound);
    end
  endtask

  logic [15:0] e;
  logic [15:0] prev_mag;
  logic [15:0] cur_mag;
  logic [7:0]  d_before;

  initial begin
    vecs[0] = '{16'hC000, 4'd8,  1'b0, 16'h4000};
    vecs[1] = '{16'hFFFF, 4'd15, 1'b0, 16'h7FFF};
    vecs[2] = '{16'h0000, 4'd15, 1'b0, 16'h8000};
    vecs[3] = '{16'h8000, 4'd8,  1'b0, 16'h0000};
    vecs[4] = '{16'hC000, 4'd0,  1'b0, 16'h0000};
    vecs[5] = '{16'hC000, 4'd8,  1'b1, 16'h0000};
    vecs[6] = '{16'h4000, 4'd8,  1'b0, 16'hC000};
    vecs[7] = '{16'h9000, 4'd4,  1'b0, 16'h0800};

    nRESET = 1'b0; smp_ce = 1'b0; sout = '0; gain = 4'd8; mute = 1'b0; aud_ready = 1'b1;

    // reset held: inputs toggling must not leak through
    for (int i = 0; i < 40; i++) begin
      smp_ce = 1'($urandom_range(0, 1));
      sout   = 16'($urandom_range(0, 65535));
      tick();
      if (i % 8 == 7) begin
        check("rst_valid", 32'(aud_valid), 0);
        check("rst_out", 32'(aud_out), 0);
        check("rst_drop", 32'(drop_cnt), 0);
      end
    end
    smp_ce = 1'b0;
    nRESET = 1'b1;
    tick();

    // vector table: each row from reset, first sample also checks the 3-cycle latency
    for (int i = 0; i < 8; i++) begin
      do_reset();
      gain = vecs[i].gain;
      mute = vecs[i].mute;
      aud_ready = 1'b1;
      send_frame(1'b0, vecs[i].sout, 2);
      e = exp_q.pop_front();
      check("vec_model", 32'(e), 32'(vecs[i].exp));
      tick(); tick();
      check("vec_lat_early", 32'(aud_valid), 0);
      tick();
      check("vec_lat_valid", 32'(aud_valid), 1);
      check("vec_out", 32'(aud_out), 32'(vecs[i].exp));
      tick();
      check("vec_consumed", 32'(aud_valid), 0);
    end
    mute = 1'b0;

    // reset mid-accumulation discards the partial sum
    do_reset();
    gain = 4'd8;
    for (int i = 0; i < 10; i++) begin
      smp_ce = 1'b1; sout = 16'hFFFF; tick();
    end
    smp_ce = 1'b0;
    do_reset();
    send_frame(1'b0, 16'hC000, 0);
    wait_valid("midrst_wait", 10);
    check("midrst_out", 32'(aud_out), 32'(exp_q.pop_front()));

    // reset with a sample in flight: no aud_valid pulse
    tick();
    send_frame(1'b0, 16'hF000, 0);
    tick();
    nRESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("inflight_rst_valid", 32'(aud_valid), 0);
    end
    nRESET = 1'b1;
    tick();
    check("inflight_rst_valid2", 32'(aud_valid), 0);

    // randomized frames vs reference model
    do_reset();
    aud_ready = 1'b1;
    for (int f = 0; f < 24; f++) begin
      gain = 4'($urandom_range(0, 15));
      mute = ($urandom_range(0, 7) == 0);
      send_frame(1'b1, 16'h0, 3);
      wait_valid("rand_wait", 10);
      check("rand_out", 32'(aud_out), 32'(exp_q.pop_front()));
      tick();
    end
    mute = 1'b0;
    check("rand_drop", 32'(drop_cnt), 0);

`ifdef STARFORC_AUDIO_DCBLOCK_EN
    // constant input: first output is the step, then magnitude decays
    do_reset();
    gain = 4'd8;
    prev_mag = 16'hFFFF;
    for (int f = 0; f < 8; f++) begin
      send_frame(1'b0, 16'hC000, 0);
      wait_valid("dc_wait", 10);
      e = exp_q.pop_front();
      check("dc_out", 32'(aud_out), 32'(e));
      if (f == 0) check("dc_first", 32'(aud_out), 32'h4000);
      cur_mag = aud_out[15] ? 16'(-aud_out) : aud_out;
      check("dc_monotonic", 32'(cur_mag <= prev_mag), 1);
      prev_mag = cur_mag;
      tick();
    end
`endif

    // back-pressure: three samples with no consumer
    do_reset();
    gain = 4'd8;
    aud_ready = 1'b0;
    send_frame(1'b0, 16'h9000, 0);
    send_frame(1'b0, 16'hA000, 0);
    send_frame(1'b0, 16'hB000, 0);
    repeat (3) tick();
    check("bp_valid", 32'(aud_valid), 1);
    check("bp_out", 32'(aud_out), 32'(exp_q[2]));
    check("bp_drop", 32'(drop_cnt), 2);
    repeat (5) tick();
    check("bp_hold", 32'(aud_out), 32'(exp_q[2]));
    for (int f = 0; f < 300; f++) send_frame(1'b1, 16'h0, 0);
    repeat (3) tick();
    check("bp_sat_drop", 32'(drop_cnt), 255);
    check("bp_sat_out", 32'(aud_out), 32'(exp_q[exp_q.size() - 1]));
    e = aud_out;
    aud_ready = 1'b1;
    tick();
    aud_ready = 1'b0;
    check("bp_drain_valid", 32'(aud_valid), 0);
    check("bp_drain_hold", 32'(aud_out), 32'(e));

    // consumer ready in the same edge a new sample lands
    do_reset();
    gain = 4'd8;
    aud_ready = 1'b0;
    send_frame(1'b0, 16'h9000, 0);
    wait_valid("sim_wait", 10);
    check("sim_first", 32'(aud_out), 32'(exp_q.pop_front()));
    d_before = drop_cnt;
    send_frame(1'b0, 16'hB000, 0);
    tick(); tick();
    aud_ready = 1'b1;
    tick();
    aud_ready = 1'b0;
    check("sim_valid", 32'(aud_valid), 1);
    check("sim_out", 32'(aud_out), 32'(exp_q.pop_front()));
    check("sim_drop", 32'(drop_cnt), 32'(d_before));
    aud_ready = 1'b1;
    tick();
    mute = 1'b1;
    send_frame(1'b0, 16'hF000, 0);
    wait_valid("mute_wait", 10);
    check("mute_out", 32'(aud_out), 32'(exp_q.pop_front()));
    check("mute_zero", 32'(aud_out), 0);
    mute = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
